srfp_addsub_pipe: RTL and testbench
===================================

Name: srfp_addsub_pipe

Overview:
- Pipelined single-precision floating-point add/subtract unit with valid/ready handshakes on input and output.
- Computes z = a + b when sub=0 and z = a - b when sub=1. Accepts one operation per cycle and has a fixed latency of 4 cycles.
- Intended as the streaming arithmetic element for FFT butterfly datapaths, in place of the flat combinational add/sub blocks.
- Keeps the library's numeric conventions:
  - truncation, no rounding;
  - underflow returns +0;
  - overflow returns the NaN pattern 32'hFFFFFFFF.

Parameters:
- GUARD, 3, extra alignment bits carried below the mantissa LSB during add/sub. They are discarded at normalize; no rounding is applied.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands a, b and sub are valid this cycle.
- in_ready  out  1  the unit can accept an operation this cycle.
- a  in  32  SP operand.
- b  in  32  SP operand.
- sub  in  1  0 selects a+b; 1 selects a-b.
- out_valid  out  1  z holds a result.
- out_ready  in  1  the consumer takes z this cycle.
- z  out  32  SP result.

Behaviour:
- Reset (async, rst_n=0):
  - all stage valid bits clear, so out_valid=0;
  - z=32'h0;
  - in_ready=1 once reset is released.
- Reset asserted mid-operation discards every in-flight operation; no partial result ever appears.
- Handshake:
  - transfer in when in_valid&&in_ready; transfer out when out_valid&&out_ready;
  - stall = out_valid && !out_ready; while stalled all stages hold and in_ready=0;
  - in_ready = !stall, combinational from out_valid and out_ready only;
  - z is stable while out_valid && !out_ready.
- Pipeline bubbles advance: an empty stage never blocks an upstream stage.
- Latency: an op accepted at edge N gives out_valid=1 after edge N+4 when no stall occurs. Throughput is 1 op/cycle; results leave in order.
- Stage 1, unpack:
  - bs_eff = b.sign ^ sub;
  - exp==0 → operand treated as zero (denormals flushed);
  - exp==255 on either input → result forced to NaN;
  - operands are swapped so that |x| >= |y|, comparing {exp,mant};
  - ediff = ex - ey, 8-bit unsigned.
- Stage 2, align:
  - mantissas are 24-bit with hidden 1, extended by GUARD zero bits;
  - my >>= ediff; if ediff >= 24+GUARD then my = 0.
- Stage 3, add:
  - if xs == ys_eff, sum = mx + my, 25+GUARD bits wide;
  - otherwise sum = mx - my, which is never negative because of the swap;
  - result sign = xs.
- Stage 4, normalize:
  - carry out (sum MSB set) → shift right 1 and exponent+1;
  - otherwise, for leading-zero count L, shift left L and exponent-L;
  - mantissa = bits below the leading one, truncated to 23 bits.
- Stage 4, result selection, in priority order:
  1. NaN flag → 32'hFFFFFFFF.
  2. Exact zero sum → 32'h00000000. Cancellation always gives +0.
  3. Exponent > 254 → NaN.
  4. Exponent < 1 → +0.
  5. Both operands zero → +0.
  6. One operand zero → the other operand, with the effective sign applied.
- Width rules:
  - exponent arithmetic uses 10-bit signed so that over/underflow can be detected;
  - the shifters are barrel shifters; no loops spanning multiple cycles.

Decomposition:
- Package srfp_pkg holds:
  - field ranges SIGN=31, EXP=30:23, MANT=22:0;
  - SP_ZERO=32'h0, SP_NAN=32'hFFFFFFFF, EXP_BIAS=127;
  - a stage payload struct {sign, exp[9:0], mant[26:0], nan, zero}.
- Sub-module sr_lzc27 is the leading-zero counter on the stage-4 sum; it is combinational and returns a 5-bit count plus an all_zero flag.
- The stage registers and handshake logic stay in the top module.

Test Plan:
- a=3f800000, b=3f800000, sub=0 → z=40000000 after 4 cycles; in_ready stays 1.
- a=3f800000, b=3f3504f3, sub=0 → z=3fda8279 (truncated); the same inputs with sub=1 → z=3e95f61a.
- a=40400000, b=40400000, sub=1 → z=00000000; also a=3f800000, b=bf800000, sub=0 → 00000000.
- a=7f7fffff, b=7f7fffff, sub=0 → z=FFFFFFFF. Also a=00800000, b=00800001, sub=1 → 00000000 (underflow).
- a=4b800000, b=3f800000, sub=0 (ediff=24) → z=4b800000. Also a=7f800000, b=anything → FFFFFFFF.
- Back-to-back backpressure:
  - stimulus: 8 ops issued back-to-back; out_ready held low on cycles 5-8, then toggled 1/0;
  - required: all 8 results in order with none lost or duplicated; in_ready=0 exactly while stalled;
  - then assert rst_n=0 with 3 ops in flight: out_valid=0 immediately and no stale result after release.

Source files
------------

// File: rtl/srfp_pkg.sv
// Shared field ranges, special encodings and the stage payload for the
// single-precision add/sub pipeline.
package srfp_pkg;

  localparam int SIGN    = 31;
  localparam int EXP_HI  = 30;
  localparam int EXP_LO  = 23;
  localparam int MANT_HI = 22;
  localparam int MANT_LO = 0;

  localparam logic [31:0] SP_ZERO = 32'h0000_0000;
  localparam logic [31:0] SP_NAN  = 32'hFFFF_FFFF;
  localparam int          EXP_BIAS = 127;

  typedef struct packed {
    logic        sign;
    logic [9:0]  exp;
    logic [26:0] mant;
    logic        nan;
    logic        zero;
  } stage_t;

endpackage

// File: rtl/sr_lzc27.sv
// Leading-zero counter for the 27-bit stage-4 sum (count=27 when all zero).
module sr_lzc27 (
  input  logic [26:0] din,
  output logic [4:0]  count,
  output logic        all_zero
);

  always_comb begin
    count    = 5'd27;
    all_zero = 1'b1;
    for (int i = 0; i < 27; i++) begin
      if (din[i]) begin
        count    = 5'(26 - i);
        all_zero = 1'b0;
      end
    end
  end

endmodule

// File: rtl/srfp_addsub_pipe.sv
// Four-stage single-precision add/subtract with valid/ready handshakes.
// Truncating, denormals flushed, underflow -> +0, overflow/Inf/NaN -> all ones.
module srfp_addsub_pipe
  import srfp_pkg::*;
#(
  parameter int GUARD = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] z
);

  // The payload mantissa and the LZC are sized for 24 + GUARD = 27 bits.
  localparam int MW = 24 + GUARD;

  logic stall, adv;
  assign stall    = out_valid && !out_ready;
  assign adv      = !stall;
  assign in_ready = !stall;

  logic        v1, v2, v3, v4;
  stage_t      x1, x2, s3, s4;
  logic        ys1, ys2, c3;
  logic [26:0] my1, my2;
  logic [7:0]  ediff1;

  // Stage 1: unpack, flush denormals, order operands by magnitude.
  logic [7:0]  ea, eb, ediff_u;
  logic [22:0] fa, fb;
  logic        az, bz, bs_eff, swap, ys_u;
  logic [26:0] my_u;
  stage_t      x_u;

  always_comb begin
    ea      = a[EXP_HI:EXP_LO];
    eb      = b[EXP_HI:EXP_LO];
    az      = (ea == 8'd0);
    bz      = (eb == 8'd0);
    fa      = az ? 23'd0 : a[MANT_HI:MANT_LO];
    fb      = bz ? 23'd0 : b[MANT_HI:MANT_LO];
    bs_eff  = b[SIGN] ^ sub;
    swap    = {eb, fb} > {ea, fa};
    x_u      = '0;
    x_u.sign = swap ? bs_eff : a[SIGN];
    x_u.exp  = {2'b00, (swap ? eb : ea)};
    x_u.mant = 27'({!(swap ? bz : az), (swap ? fb : fa)}) << GUARD;
    x_u.nan  = (ea == 8'hFF) || (eb == 8'hFF);
    x_u.zero = az && bz;
    ys_u     = swap ? a[SIGN] : bs_eff;
    my_u     = 27'({!(swap ? az : bz), (swap ? fa : fb)}) << GUARD;
    ediff_u  = swap ? (eb - ea) : (ea - eb);
  end

  // Stage 2: align the smaller mantissa.
  logic [26:0] my_a;
  assign my_a = (ediff1 >= 8'(MW)) ? 27'd0 : (my1 >> ediff1);

  // Stage 3: magnitude add or subtract; the swap keeps the difference non-negative.
  logic [27:0] sum_c;
  stage_t      s3_d;

  always_comb begin
    if (x2.sign == ys2) sum_c = {1'b0, x2.mant} + {1'b0, my2};
    else                sum_c = {1'b0, x2.mant} - {1'b0, my2};
    s3_d      = x2;
    s3_d.mant = sum_c[26:0];
  end

  // Stage 4: normalize.
  logic [4:0] lz;
  logic       lz_zero;
  stage_t     n_d;

  sr_lzc27 u_lzc (
    .din      (s3.mant),
    .count    (lz),
    .all_zero (lz_zero)
  );

  always_comb begin
    n_d = s3;
    if (c3) begin
      n_d.mant = {1'b1, s3.mant[26:1]};
      n_d.exp  = s3.exp + 10'd1;
    end else begin
      n_d.mant = s3.mant << lz;
      n_d.exp  = s3.exp - {5'd0, lz};
      n_d.zero = s3.zero || lz_zero;
    end
  end

  logic [31:0] res;

  always_comb begin
    if (s4.nan)                                          res = SP_NAN;
    else if (s4.zero)                                    res = SP_ZERO;
    else if ($signed(s4.exp) > $signed(10'(2 * EXP_BIAS))) res = SP_NAN;
    else if ($signed(s4.exp) < $signed(10'd1))           res = SP_ZERO;
    else res = {s4.sign, s4.exp[7:0], s4.mant[MW-2 -: 23]};
  end

  logic unused_bits;
  assign unused_bits = ^{s4.mant[26], s4.mant[GUARD-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      v4        <= 1'b0;
      out_valid <= 1'b0;
      x1        <= '0;
      x2        <= '0;
      s3        <= '0;
      s4        <= '0;
      ys1       <= 1'b0;
      ys2       <= 1'b0;
      c3        <= 1'b0;
      my1       <= '0;
      my2       <= '0;
      ediff1    <= '0;
      z         <= SP_ZERO;
    end else if (adv) begin
      v1        <= in_valid;
      x1        <= x_u;
      ys1       <= ys_u;
      my1       <= my_u;
      ediff1    <= ediff_u;
      v2        <= v1;
      x2        <= x1;
      ys2       <= ys1;
      my2       <= my_a;
      v3        <= v2;
      s3        <= s3_d;
      c3        <= sum_c[27];
      v4        <= v3;
      s4        <= n_d;
      out_valid <= v4;
      if (v4) z <= res;
    end
  end

endmodule

// File: tb/tb_srfp_addsub_pipe.sv
// Bench for srfp_addsub_pipe: directed vectors, random streams with
// backpressure, and mid-flight reset, against a behavioural model.
module tb_srfp_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] z;

  int n_checks = 0;
  int n_fail = 0;
  int n_out = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  srfp_addsub_pipe #(.GUARD(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Reference: signed integer arithmetic on the aligned, guard-extended
  // mantissas, then locate the leading one and truncate to 23 fraction bits.
  function automatic logic [31:0] ref_fp(input logic [31:0] ta, input logic [31:0] tb_, input logic ts);
    int ea, eb, ex, d, p, e;
    longint ma, mb, mx, my, s, mag, frac;
    bit sa, sb, sx, sy, neg;
    ea = int'(ta[30:23]);
    eb = int'(tb_[30:23]);
    if (ea == 255 || eb == 255) return 32'hFFFF_FFFF;
    sa = ta[31];
    sb = tb_[31] ^ ts;
    ma = (ea == 0) ? longint'(0) : longint'(ta[22:0]) + (longint'(1) << 23);
    mb = (eb == 0) ? longint'(0) : longint'(tb_[22:0]) + (longint'(1) << 23);
    if (eb > ea || (eb == ea && mb > ma)) begin
      ex = eb; d = eb - ea; mx = mb; my = ma; sx = sb; sy = sa;
    end else begin
      ex = ea; d = ea - eb; mx = ma; my = mb; sx = sa; sy = sb;
    end
    mx = mx * 8;
    my = (d >= 27) ? longint'(0) : ((my * 8) >> d);
    s = (sx ? -mx : mx) + (sy ? -my : my);
    if (s == 0) return 32'h0;
    neg = (s < 0);
    mag = neg ? -s : s;
    p = 0;
    while ((mag >> (p + 1)) != 0) p++;
    e = ex + p - 26;
    if (e > 254) return 32'hFFFF_FFFF;
    if (e < 1) return 32'h0;
    frac = (p >= 23) ? (mag >> (p - 23)) : (mag << (23 - p));
    return {neg, 8'(e), frac[22:0]};
  endfunction

  function automatic logic [31:0] rnd_fp(input int base_e);
    int e, m;
    logic [31:0] r;
    r = $urandom;
    m = $urandom_range(0, 15);
    if (m == 0)      e = 0;
    else if (m == 1) e = 255;
    else if (m == 2) e = $urandom_range(1, 4);
    else if (m == 3) e = $urandom_range(250, 254);
    else begin
      e = base_e + $urandom_range(0, 60) - 30;
      if (e < 1) e = 1;
      if (e > 254) e = 254;
    end
    r[30:23] = 8'(e);
    return r;
  endfunction

  task automatic new_op();
    a = rnd_fp($urandom_range(1, 254));
    if ($urandom_range(0, 9) == 0) b = a;
    else b = rnd_fp(int'(a[30:23]));
    sub = 1'($urandom_range(0, 1));
  endtask

  function automatic logic bp_ready(input int c);
    if (c >= 5 && c <= 8) return 1'b0;
    if (c > 8) return 1'(c % 2);
    return 1'b1;
  endfunction

  // Scoreboard and handshake monitor, sampled mid-cycle.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_z = 32'h0;

  always @(negedge clk) begin
    if (rst_n) begin
      check_eq("in_ready", {31'b0, in_ready}, {31'b0, !(out_valid && !out_ready)});
      if (prev_stall) begin
        check_eq("stall_hold_valid", {31'b0, out_valid}, 32'd1);
        check_eq("stall_hold_z", z, prev_z);
      end
      if (in_valid && in_ready) exp_q.push_back(ref_fp(a, b, sub));
      if (out_valid && out_ready) begin
        n_out <= n_out + 1;
        check_eq("out_has_op", {31'b0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) check_eq("z", z, exp_q.pop_front());
      end
      prev_stall <= out_valid && !out_ready;
      prev_z     <= z;
    end else begin
      prev_stall <= 1'b0;
    end
  end

  task automatic directed(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                          input logic ts, input logic [31:0] want);
    int lat;
    @(posedge clk); #1;
    a = ta; b = tb_; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, "_lat"}, 32'(lat), 32'd4);
    check_eq(tag, z, want);
  endtask

  task automatic run_stream(input int n_ops, input int pv, input int pr, input bit bp);
    int issued, cyc;
    bit took;
    issued = 0;
    cyc = 0;
    @(posedge clk); #1;
    new_op();
    in_valid  = bp || ($urandom_range(0, 99) < pv);
    out_ready = bp ? bp_ready(1) : ($urandom_range(0, 99) < pr);
    while ((issued < n_ops || exp_q.size() != 0) && cyc < 4000) begin
      @(negedge clk);
      took = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++;
      if (took) begin
        issued++;
        new_op();
      end
      if (issued >= n_ops) in_valid = 1'b0;
      else if (took || !in_valid) in_valid = bp || ($urandom_range(0, 99) < pv);
      out_ready = bp ? bp_ready(cyc + 1) : ($urandom_range(0, 99) < pr);
    end
    check_eq("stream_done", {31'b0, cyc < 4000}, 32'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    int n0;
    #3;
    check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("rst_z", z, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check_eq("rst_in_ready", {31'b0, in_ready}, 32'd1);

    directed("one_plus_one", 32'h3f800000, 32'h3f800000, 1'b0, 32'h40000000);
    directed("add_trunc",    32'h3f800000, 32'h3f3504f3, 1'b0, 32'h3fda8279);
    directed("sub_trunc",    32'h3f800000, 32'h3f3504f3, 1'b1, 32'h3e95f61a);
    directed("cancel_sub",   32'h40400000, 32'h40400000, 1'b1, 32'h00000000);
    directed("cancel_add",   32'h3f800000, 32'hbf800000, 1'b0, 32'h00000000);
    directed("overflow",     32'h7f7fffff, 32'h7f7fffff, 1'b0, 32'hFFFFFFFF);
    directed("underflow",    32'h00800000, 32'h00800001, 1'b1, 32'h00000000);
    directed("ediff_24",     32'h4b800000, 32'h3f800000, 1'b0, 32'h4b800000);
    directed("inf_in",       32'h7f800000, 32'h3f800000, 1'b0, 32'hFFFFFFFF);
    directed("zero_plus_x",  32'h00000000, 32'h40a00000, 1'b1, 32'hc0a00000);

    run_stream(300, 100, 100, 1'b0);
    run_stream(300, 70, 60, 1'b0);

    n0 = n_out;
    run_stream(8, 100, 100, 1'b1);
    check_eq("bp_count", 32'(n_out - n0), 32'd8);

    n0 = n_out;
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      new_op();
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("midrst_z", z, 32'h0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check_eq("midrst_no_stale", 32'(n_out - n0), 32'd0);
    check_eq("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    check_eq("final_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1);
  end

endmodule
